// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prbs_pkg
// Brief   : Shared PRBS types and generator-matched default recurrence taps.
// Revision: 1.0
// ============================================================================
package prbs_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Serial output of the 5-bit generator, including its registered feedback stage
    localparam int c_prbs_len = 6;
    localparam int c_prbs_tap = 4;

endpackage
`default_nettype wire

// File: rtl/prbs_predictor.sv
`default_nettype none
// ============================================================================
// Module  : prbs_predictor
// Brief   : History shift register, next-bit prediction and all-zero detect.
// Revision: 1.0
// ============================================================================
module prbs_predictor
    import prbs_pkg::*;
#(
    parameter int LEN = c_prbs_len,
    parameter int TAP = c_prbs_tap
) (
    input  logic clk,
    input  logic reset,
    input  logic i_shift,
    input  logic i_use_pred,
    input  logic i_bit,
    output logic o_pred,
    output logic o_next_zero
);

    logic [LEN-1:0] hist_q;
    logic [LEN-1:0] hist_d;
    logic           w_src;

    assign o_pred = hist_q[LEN-1] ^ hist_q[TAP-1];

    always_comb begin
        w_src  = i_use_pred ? o_pred : i_bit;
        hist_d = hist_q;
        if (i_shift) begin
            hist_d = {hist_q[LEN-2:0], w_src};
        end
    end

    // Evaluated on the post-shift value so VERIFY can reject a dead sequence
    assign o_next_zero = (hist_d == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module  : prbs_checker
// Brief   : Serial PRBS lock/verify checker with windowed loss-of-lock.
// Revision: 1.0
// ============================================================================
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LEN      = c_prbs_len,
    parameter int TAP      = c_prbs_tap,
    parameter int LOCK_N   = 12,
    parameter int WINDOW   = 64,
    parameter int UNLOCK_N = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int c_fill_w = $clog2(LEN + 1);
    localparam int c_good_w = $clog2(LOCK_N + 1);
    localparam int c_win_w  = $clog2(WINDOW + 1);
    localparam int c_werr_w = $clog2(UNLOCK_N + 1);

    state_e              state_q,     state_d;
    logic [c_fill_w-1:0] fill_cnt_q,  fill_cnt_d;
    logic [c_good_w-1:0] good_cnt_q,  good_cnt_d;
    logic [c_win_w-1:0]  win_cnt_q,   win_cnt_d;
    logic [c_werr_w-1:0] win_err_q,   win_err_d;
    logic                locked_q,    locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;

    logic w_pred;
    logic w_next_zero;
    logic w_mismatch;
    logic w_err_inc;

    prbs_predictor #(
        .LEN (LEN),
        .TAP (TAP)
    ) u_predictor (
        .clk         (clk),
        .reset       (reset),
        .i_shift     (in_valid),
        .i_use_pred  (state_q == LOCKED),
        .i_bit       (in_bit),
        .o_pred      (w_pred),
        .o_next_zero (w_next_zero)
    );

    assign w_mismatch = in_bit ^ w_pred;

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        good_cnt_d  = good_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        w_err_inc   = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                FILL: begin
                    if (fill_cnt_q == c_fill_w'(LEN - 1)) begin
                        state_d    = VERIFY;
                        fill_cnt_d = '0;
                        good_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
                VERIFY: begin
                    if (w_next_zero) begin
                        state_d    = FILL;
                        fill_cnt_d = '0;
                        good_cnt_d = '0;
                    end else if (w_mismatch) begin
                        good_cnt_d = '0;
                    end else if (good_cnt_q == c_good_w'(LOCK_N - 1)) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    err_pulse_d = w_mismatch;
                    w_err_inc   = w_mismatch;
                    // Loss of lock wins over a window rollover on the same bit
                    if (w_mismatch && (win_err_q == c_werr_w'(UNLOCK_N - 1))) begin
                        state_d    = FILL;
                        fill_cnt_d = '0;
                    end else if (win_cnt_q == c_win_w'(WINDOW - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_q + c_werr_w'(w_mismatch);
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end

        err_count_d = err_count_q;
        if (clear_cnt) begin
            err_count_d = '0;
        end else if (w_err_inc && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            good_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            good_cnt_q  <= good_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: doc/prbs_checker.md
# prbs_checker

Serial pseudo-random sequence checker. It is the receive-side counterpart of the team's 5-bit LFSR pattern generator. It consumes the generator's serial output (bit 0 of its state, one bit per accepted cycle), locks onto the sequence, then flags and counts every bit that deviates from the predicted stream. It sits at the sink end of loopback/BIST paths and exposes lock status and a saturating error count to the control logic.

## Interface
Parameters:
- LEN, default 6: history length; the recurrence is s[n] = s[n-LEN] ^ s[n-TAP]. The defaults match the generator's serial output, including its registered feedback stage.
- TAP, default 4: second tap position, 1 ≤ TAP < LEN.
- LOCK_N, default 12: consecutive correct predictions required to declare lock.
- WINDOW, default 64: accepted-bit window length for loss-of-lock evaluation.
- UNLOCK_N, default 8: errors within one WINDOW that force loss of lock.
- CNT_W, default 16: error counter width.

Ports:
- clk  in  1  the single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- in_valid  in  1  in_bit is accepted on this cycle.
- in_bit  in  1  received serial bit.
- clear_cnt  in  1  synchronously zeroes err_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while locked.
- err_count  out  CNT_W  saturating count of mismatches while locked.

## Operation
- State hist[LEN-1:0] holds the most recent LEN bits; hist[0] is the newest. Prediction p = hist[LEN-1] ^ hist[TAP-1].
- Cycles with in_valid=0 change no state, counter or output, except that err_pulse returns to 0 and clear_cnt still takes effect.
- FSM states: FILL, VERIFY, LOCKED.
- FILL: shift in_bit into hist on each valid cycle. After LEN valid bits, go to VERIFY with good_cnt=0.
- VERIFY: on each valid bit, compare in_bit with p and shift in_bit into hist.
  - Match: good_cnt+1. When good_cnt reaches LOCK_N, go to LOCKED and clear win_cnt and win_err.
  - Mismatch: good_cnt=0 and stay in VERIFY.
  - If the post-shift hist is all zero, it is illegal (the sequence cannot lock on zeros). Go to FILL and reset the fill count.
- LOCKED: runs as a flywheel. The predicted bit p, not in_bit, is shifted into hist, so one line error produces exactly one error count.
  - Mismatch: err_pulse=1 next cycle; err_count+1, saturating at all-ones; win_err+1.
  - win_cnt counts valid bits. When win_cnt completes WINDOW bits, win_cnt and win_err both clear.
  - If win_err reaches UNLOCK_N, go to FILL on that cycle; locked falls next cycle. err_count is retained.
- clear_cnt has priority over an increment on the same cycle; the result is 0.
- Reset: state FILL, hist=0, all internal counters 0, locked=0, err_pulse=0, err_count=0. Reset mid-stream discards history fully, and relock starts from FILL.

## Timing
- All outputs are registered, with one-cycle latency from the accepting edge.
- Lock latency from reset release with a continuous valid stream: LEN + LOCK_N accepted bits, then locked=1 on the following cycle.
- err_pulse is high for exactly one cycle per erroneous accepted bit. Back-to-back errors on consecutive valid cycles keep it high continuously.
- A loss of lock and an err_pulse for the same bit appear together on the same cycle.
- No backpressure: every in_valid=1 cycle is consumed.

## Structure
- Shared package prbs_pkg holds:
  - the state enum type (FILL, VERIFY, LOCKED);
  - default constants for LEN/TAP matching the generator, so generator and checker cannot drift.
- One sub-module, prbs_predictor: holds hist, the shift-source mux (in_bit or p), the prediction p, and all-zero detection.
- The FSM and counters stay in the top module.

## Test plan
- Generator output fed with in_valid=1 continuously from reset release: locked=1 after 18 bits plus 1 cycle; err_count stays 0 over 1000 bits.
- After lock, invert one bit: exactly one err_pulse, err_count=1, locked stays 1, and following bits produce no further errors.
- After lock, invert 8 bits within 64: locked drops the cycle after the 8th error; err_count=8; relock after 18 more good bits.
- All-zero input for 40 cycles: locked never rises, and the FSM cycles between FILL and VERIFY.
- Random in_valid gaps (~50% duty) with the generator stream: lock and error behaviour identical in valid-bit terms; outputs frozen during gaps.
- err_count saturation with CNT_W=4: 20 injected errors give err_count=15. Asserting clear_cnt together with an error gives 0. Reset (reset=0) mid-LOCKED gives locked=0 and err_count=0 the next cycle.
